// File: rtl/io_timer.sv
// io_timer: memory-mapped prescaled 32-bit timer with compare-match,
// optional auto-reload and a registered level interrupt.
// Optional feature: define IO_TIMER_CYCLE_COUNTER_EN to add a free-running
// 64-bit cycle counter at 0x14 with a 64-bit snapshot at 0x18/0x1C.
module io_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  output logic [31:0] data_out,
  output logic        irq
);

  // Word indices within the peripheral window (addr[5:2]).
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PRESCALE = 4'h1;
  localparam logic [3:0] REG_COUNT    = 4'h2;
  localparam logic [3:0] REG_COMPARE  = 4'h3;
  localparam logic [3:0] REG_STATUS   = 4'h4;
`ifdef IO_TIMER_CYCLE_COUNTER_EN
  localparam logic [3:0] REG_CYC_LIVE = 4'h5;
  localparam logic [3:0] REG_SNAP_LO  = 4'h6;
  localparam logic [3:0] REG_SNAP_HI  = 4'h7;
`endif

  logic [2:0]            ctrl_reg, ctrl_next;       // {IE, RELOAD, EN}
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
  logic [31:0]           count_reg, count_next;
  logic [31:0]           compare_reg, compare_next;
  logic                  match_reg, match_next;
  logic                  irq_reg, irq_next;

  logic [3:0] word_idx;
  logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic       tick;
  logic       count_hit;
  logic       unused_addr_bits;

  assign word_idx         = addr[5:2];
  assign unused_addr_bits = ^addr[1:0];

  assign wr_ctrl     = write_enable && (word_idx == REG_CTRL);
  assign wr_prescale = write_enable && (word_idx == REG_PRESCALE);
  assign wr_count    = write_enable && (word_idx == REG_COUNT);
  assign wr_compare  = write_enable && (word_idx == REG_COMPARE);
  assign wr_status   = write_enable && (word_idx == REG_STATUS);

  // Ticks follow the registered EN, so a CTRL write only matters next cycle.
  assign tick      = ctrl_reg[0] && (pcnt_reg == prescale_reg);
  assign count_hit = (count_reg == compare_reg);

  // Next-state logic for the timer registers and the prescaler.
  always_comb begin
    ctrl_next     = wr_ctrl     ? data_in[2:0]            : ctrl_reg;
    prescale_next = wr_prescale ? data_in[PRESCALE_W-1:0] : prescale_reg;
    compare_next  = wr_compare  ? data_in                 : compare_reg;

    // Prescaler restarts on any COUNT/PRESCALE write so the next tick is a full period away.
    if (wr_count || wr_prescale || !ctrl_reg[0] || tick) begin
      pcnt_next = '0;
    end else begin
      pcnt_next = pcnt_reg + PRESCALE_W'(1);
    end

    // A COUNT store beats the increment/reload; the match check still sees the old COUNT.
    if (wr_count) begin
      count_next = data_in;
    end else if (tick) begin
      count_next = (count_hit && ctrl_reg[1]) ? 32'd0 : count_reg + 32'd1;
    end else begin
      count_next = count_reg;
    end

    // A fresh match outranks a simultaneous W1C.
    if (tick && count_hit) begin
      match_next = 1'b1;
    end else if (wr_status && data_in[0]) begin
      match_next = 1'b0;
    end else begin
      match_next = match_reg;
    end

    irq_next = match_reg & ctrl_reg[2];
  end

  // Timer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      count_reg    <= '0;
      compare_reg  <= '0;
      match_reg    <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      match_reg    <= match_next;
      irq_reg      <= irq_next;
    end
  end

  assign irq = irq_reg;

`ifdef IO_TIMER_CYCLE_COUNTER_EN
  logic [63:0] cyc_reg;
  logic [63:0] snap_reg;
  logic        wr_snap;

  assign wr_snap = write_enable && (word_idx == REG_CYC_LIVE);

  // Free-running cycle counter and snapshot capture; independent of EN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_reg  <= '0;
      snap_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 64'd1;
      if (wr_snap) begin
        snap_reg <= cyc_reg;
      end
    end
  end
`endif

  // Zero-latency read mux; unmapped offsets return zero.
  always_comb begin
    data_out = 32'd0;
    case (word_idx)
      REG_CTRL:     data_out[2:0] = ctrl_reg;
      REG_PRESCALE: data_out[PRESCALE_W-1:0] = prescale_reg;
      REG_COUNT:    data_out = count_reg;
      REG_COMPARE:  data_out = compare_reg;
      REG_STATUS:   data_out[0] = match_reg;
`ifdef IO_TIMER_CYCLE_COUNTER_EN
      REG_CYC_LIVE: data_out = cyc_reg[31:0];
      REG_SNAP_LO:  data_out = snap_reg[31:0];
      REG_SNAP_HI:  data_out = snap_reg[63:32];
`endif
      default:      data_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed testbench for io_timer; inputs change and outputs are sampled
// around the falling edge so they never race the active rising edge.
module tb_io_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  addr = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic        write_enable = 1'b0;
  logic [31:0] data_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_timer #(.PRESCALE_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One store: held across exactly one rising edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr = a;
    data_in = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checks++;
    assert (data_out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
    end
    $display("check %s addr=%h data_out=%h expected=%h", tag, a, data_out, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    #1;
    checks++;
    assert (irq === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, irq, exp);
    end
    $display("check %s irq=%b expected=%b", tag, irq, exp);
  endtask

  initial begin
    // Reset state: every offset reads zero while reset is held.
    step(3);
    for (int i = 0; i < 8; i++) begin
      rd_chk("reset_rd", 6'(i * 4), 32'd0);
    end
    irq_chk("reset_irq", 1'b0);
    rst_n = 1'b1;

    // Snapshot: release at cycle 0, write 0x14 on the 5th edge (counter = 4).
    step(4);
    wr(6'h14, 32'd0);
`ifdef IO_TIMER_CYCLE_COUNTER_EN
    rd_chk("snap_lo", 6'h18, 32'd4);
    rd_chk("snap_hi", 6'h1C, 32'd0);
    rd_chk("cyc_live", 6'h14, 32'd5);
    step(5);
    rd_chk("snap_lo_hold", 6'h18, 32'd4);
    rd_chk("cyc_live2", 6'h14, 32'd10);
`else
    rd_chk("snap_lo_off", 6'h18, 32'd0);
    rd_chk("snap_hi_off", 6'h1C, 32'd0);
    rd_chk("cyc_live_off", 6'h14, 32'd0);
`endif

    // Register readback, masking and unmapped offsets.
    wr(6'h00, 32'hFFFF_FFF8);
    rd_chk("ctrl_mask", 6'h00, 32'd0);
    wr(6'h04, 32'hABCD_1234);
    rd_chk("prescale_mask", 6'h04, 32'h0000_1234);
    wr(6'h0C, 32'h1234_5678);
    rd_chk("compare_rb", 6'h0C, 32'h1234_5678);
    wr(6'h20, 32'hDEAD_BEEF);
    rd_chk("unmapped_20", 6'h20, 32'd0);
    rd_chk("unmapped_3c", 6'h3C, 32'd0);

    // Free-running count, prescale 0: one increment per clock after EN.
    wr(6'h04, 32'd0);
    wr(6'h0C, 32'hFFFF_FFFF);
    wr(6'h08, 32'd0);
    wr(6'h00, 32'h1);
    step(10);
    rd_chk("free_count10", 6'h08, 32'd10);
    rd_chk("free_nomatch", 6'h10, 32'd0);
    wr(6'h00, 32'h0);            // tick in this cycle still counts (old EN)
    step(3);
    rd_chk("free_stopped", 6'h08, 32'd11);

    // Periodic: prescale 3, compare 4, reload+IE -> match every 20 clocks.
    wr(6'h04, 32'd3);
    wr(6'h0C, 32'd4);
    wr(6'h08, 32'd0);
    wr(6'h00, 32'h7);            // edge E0
    step(19);
    rd_chk("per_pre_match", 6'h10, 32'd0);
    irq_chk("per_pre_irq", 1'b0);
    step(1);                     // E20
    rd_chk("per_match1", 6'h10, 32'd1);
    rd_chk("per_reload", 6'h08, 32'd0);
    irq_chk("per_irq_lag", 1'b0);
    step(1);                     // E21
    irq_chk("per_irq1", 1'b1);
    wr(6'h10, 32'h1);            // E22 W1C
    rd_chk("per_w1c", 6'h10, 32'd0);
    irq_chk("per_irq_hold", 1'b1);
    step(1);                     // E23
    irq_chk("per_irq_drop", 1'b0);
    step(16);                    // E39
    rd_chk("per_pre_match2", 6'h10, 32'd0);
    step(1);                     // E40
    rd_chk("per_match2", 6'h10, 32'd1);
    step(1);                     // E41
    irq_chk("per_irq2", 1'b1);
    wr(6'h00, 32'h3);            // E42: IE off, irq still from old IE
    irq_chk("ie_off_hold", 1'b1);
    step(1);
    irq_chk("ie_off_drop", 1'b0);
    wr(6'h00, 32'h0);
    wr(6'h10, 32'h0);
    rd_chk("w1c_zero_noop", 6'h10, 32'd1);
    wr(6'h10, 32'h1);
    rd_chk("w1c_clear", 6'h10, 32'd0);

    // Wrap: 0xFFFFFFFE -> 0xFFFFFFFF -> match, wraps to 0 (no reload).
    wr(6'h04, 32'd0);
    wr(6'h0C, 32'hFFFF_FFFF);
    wr(6'h08, 32'hFFFF_FFFE);
    wr(6'h00, 32'h1);
    step(1);
    rd_chk("wrap_tick1", 6'h08, 32'hFFFF_FFFF);
    rd_chk("wrap_nomatch", 6'h10, 32'd0);
    step(1);
    rd_chk("wrap_match", 6'h10, 32'd1);
    rd_chk("wrap_zero", 6'h08, 32'd0);
    wr(6'h00, 32'h0);
    step(2);
    rd_chk("wrap_stop", 6'h08, 32'd1);

    // Collision: COUNT store in the matching tick cycle.
    wr(6'h10, 32'h1);
    wr(6'h0C, 32'd5);
    wr(6'h08, 32'd3);
    wr(6'h00, 32'h1);
    step(2);
    rd_chk("coll_pre_cnt", 6'h08, 32'd5);
    rd_chk("coll_pre_match", 6'h10, 32'd0);
    wr(6'h08, 32'd100);
    rd_chk("coll_match", 6'h10, 32'd1);
    rd_chk("coll_count", 6'h08, 32'd100);
    step(1);
    rd_chk("coll_next", 6'h08, 32'd101);

    // Collision: W1C in the cycle a new match is set.
    wr(6'h00, 32'h0);
    wr(6'h10, 32'h1);
    wr(6'h08, 32'd3);
    wr(6'h00, 32'h1);
    step(2);
    rd_chk("w1cc_pre", 6'h10, 32'd0);
    wr(6'h10, 32'h1);
    rd_chk("w1cc_set_wins", 6'h10, 32'd1);
    rd_chk("w1cc_count", 6'h08, 32'd6);
    wr(6'h00, 32'h4);
    step(1);
    irq_chk("ie_only_irq", 1'b1);

    // Reset mid-operation beats a concurrent COUNT store.
    addr = 6'h08;
    data_in = 32'h55;
    write_enable = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    write_enable = 1'b0;
    rst_n = 1'b1;
    rd_chk("rst_count", 6'h08, 32'd0);
    rd_chk("rst_status", 6'h10, 32'd0);
    rd_chk("rst_ctrl", 6'h00, 32'd0);
    irq_chk("rst_irq", 1'b0);
    step(3);
    rd_chk("rst_no_resume", 6'h08, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
